rv32i_forwarding_ctrl: RTL and testbench
========================================

Name: rv32i_forwarding_ctrl

Overview:
Parametrised successor to the core's operand-forwarding logic. Resolves RAW hazards for NUM_RD_PORTS source operands against NUM_FWD_STAGES downstream pipeline stages, youngest stage first. It adds a per-port operand capture buffer, which keeps a forwarded value after its producer has retired while the ALU stage is held. It also adds a consecutive-stall watchdog and a stall performance counter. Sits between the basereg read and the ALU stage operand muxes.

Parameters:
XLEN, 32, data width
AW, 5, register address width
NUM_RD_PORTS, 2, source operands per instruction (port 0 = rs1, port 1 = rs2)
NUM_FWD_STAGES, 2, forwarding stages; index 0 = youngest (MEMORYACCESS), last = oldest (WRITEBACK)
STALL_TIMEOUT, 15, consecutive-stall count that raises o_stall_timeout
CNT_W, 32, width of stall performance counter

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset; active-high
i_rs_orig  in  NUM_RD_PORTS*XLEN  basereg values, port p at [p*XLEN +: XLEN]
i_rs_addr  in  NUM_RD_PORTS*AW  operand addresses in ALU stage
i_alu_ce  in  1  ALU stage consumes operands this cycle (instruction advances)
i_flush  in  1  pipeline flush; discards captured operands
i_stg_rd_addr  in  NUM_FWD_STAGES*AW  destination address per stage
i_stg_wr_rd  in  NUM_FWD_STAGES  stage will write rd
i_stg_rd_valid  in  NUM_FWD_STAGES  rd data already valid in stage (not LOAD/CSR)
i_stg_rd  in  NUM_FWD_STAGES*XLEN  rd value per stage
i_stg_ce  in  NUM_FWD_STAGES  stage enabled
o_rs  out  NUM_RD_PORTS*XLEN  forwarded operand values
o_alu_force_stall  out  1  hold ALU stage
o_stall_timeout  out  1  one-cycle pulse on watchdog expiry
o_stall_total  out  CNT_W  saturating count of cycles with o_alu_force_stall=1

Behaviour:
- Hit(p,s) = (rs_addr[p]==stg_rd_addr[s]) & stg_wr_rd[s] & stg_ce[s] & (rs_addr[p]!=0).
- Winning stage for port p = lowest s with Hit(p,s). Younger stages always win over older stages.
- o_rs[p] is combinational. Priority:
  1. rs_addr[p]==0 gives 0.
  2. Otherwise, a winning stage gives stg_rd[win].
  3. Otherwise, cap_vld[p] gives cap_data[p].
  4. Otherwise, i_rs_orig[p].
- Stall: o_alu_force_stall = OR over p of (winner exists & !stg_rd_valid[win]). It is forced to 0 while i_rst=1. A valid older-stage hit never masks an invalid younger-stage winner.
- Capture buffer (per port, registered):
  - if i_rst | i_flush | i_alu_ce: cap_vld <= 0.
  - else if winner exists & stg_rd_valid[win]: cap_vld <= 1, cap_data <= stg_rd[win]. Re-capture overwrites, so the newest producer wins.
  - else: hold.
  - i_alu_ce and a capture in the same cycle: clear wins, because the operand is consumed that cycle.
- Stall watchdog: stall_run counts consecutive cycles with o_alu_force_stall=1. It resets to 0 on any cycle without a stall, and saturates at STALL_TIMEOUT.
  - o_stall_timeout = 1 for exactly the cycle after stall_run transitions to STALL_TIMEOUT.
  - No re-pulse until the stall breaks.
- o_stall_total increments on each stalled cycle and saturates at 2^CNT_W-1. It is not cleared by i_flush.
- Reset values: cap_vld=0, cap_data=0, stall_run=0, o_stall_timeout=0, o_stall_total=0.
- Reset mid-stall: all state clears on the next edge. Outputs then follow the combinational rules with empty capture.
- Latency: forwarding and stall are same-cycle. Capture takes effect from the next cycle.

Test Plan:
- Back-to-back ALU: rs_addr[0]=5; stg0 rd_addr=5, wr=1, ce=1, valid=1, rd=0x11; stg1 rd_addr=5, rd=0x22 -> o_rs[0]=0x11, stall=0.
- Load-use: stg0 rd_addr=7, valid=0, rs_addr[1]=7 -> stall=1. Next cycle the load sits in stg1 (valid, rd=0xABCD) and stg0 is disabled -> stall=0, o_rs[1]=0xABCD.
- Capture hold: i_alu_ce=0 while stg1 forwards 0x55 to rs_addr[0]=3; next cycle no stage hits and i_rs_orig[0]=0x0 -> o_rs[0]=0x55. Asserting i_alu_ce or i_flush -> following cycle o_rs[0]=i_rs_orig[0].
- x0: rs_addr[0]=0 with stg0 rd_addr=0, wr=1, valid=0 -> o_rs[0]=0, stall=0.
- Watchdog: hold a load-use stall for 20 cycles -> o_stall_timeout high only in cycle 16, o_stall_total=20. Release the stall, then stall again for 15 cycles -> a second pulse.
- Reset mid-stall: i_rst=1 for one cycle during capture/stall -> cap_vld=0, o_stall_total=0, o_alu_force_stall=0 during reset.

Source files
------------

// File: rtl/rv32i_forwarding_ctrl.sv
// rv32i_forwarding_ctrl
// Resolves read-after-write hazards for the ALU-stage source operands. Each
// operand is checked against the downstream pipeline stages, and the youngest
// matching stage supplies the value. A per-port capture buffer keeps a
// forwarded value after its producer retires while the ALU stage is held. A
// consecutive-stall watchdog and a saturating stall counter are also provided.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_rs_orig             basereg operand values, port p at [p*XLEN +: XLEN]
//   i_rs_addr             operand register addresses, port p at [p*AW +: AW]
//   i_alu_ce              ALU stage consumes its operands this cycle
//   i_flush               pipeline flush, discards captured operands
//   i_stg_rd_addr         destination address per stage (index 0 = youngest)
//   i_stg_wr_rd           stage will write rd
//   i_stg_rd_valid        rd data already available in the stage
//   i_stg_rd              rd value per stage
//   i_stg_ce              stage enabled
//   o_rs                  forwarded operand values (combinational)
//   o_alu_force_stall     hold the ALU stage (combinational)
//   o_stall_timeout       one-cycle pulse when the watchdog expires
//   o_stall_total         saturating count of stalled cycles
module rv32i_forwarding_ctrl #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned AW             = 5,
  parameter int unsigned NUM_RD_PORTS   = 2,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned STALL_TIMEOUT  = 15,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_RD_PORTS*XLEN-1:0]   i_rs_orig,
  input  logic [NUM_RD_PORTS*AW-1:0]     i_rs_addr,
  input  logic                           i_alu_ce,
  input  logic                           i_flush,
  input  logic [NUM_FWD_STAGES*AW-1:0]   i_stg_rd_addr,
  input  logic [NUM_FWD_STAGES-1:0]      i_stg_wr_rd,
  input  logic [NUM_FWD_STAGES-1:0]      i_stg_rd_valid,
  input  logic [NUM_FWD_STAGES*XLEN-1:0] i_stg_rd,
  input  logic [NUM_FWD_STAGES-1:0]      i_stg_ce,
  output logic [NUM_RD_PORTS*XLEN-1:0]   o_rs,
  output logic                           o_alu_force_stall,
  output logic                           o_stall_timeout,
  output logic [CNT_W-1:0]               o_stall_total
);

  localparam int unsigned RUN_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STALL_TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STALL_TIMEOUT - 1);

  // Per-port winning-stage results
  logic [NUM_RD_PORTS-1:0] addr_zero;
  logic [NUM_RD_PORTS-1:0] win_any;
  logic [NUM_RD_PORTS-1:0] win_vld;
  logic [XLEN-1:0]         win_data [NUM_RD_PORTS];

  // Capture buffer
  logic [NUM_RD_PORTS-1:0] cap_vld;
  logic [XLEN-1:0]         cap_data [NUM_RD_PORTS];

  // Watchdog
  logic [RUN_W-1:0]        stall_run;
  logic                    stall_raw;

  // Winner search: stages are scanned oldest to youngest so that the
  // youngest hitting stage is the last to write, and therefore wins.
  always_comb begin
    addr_zero = '0;
    win_any   = '0;
    win_vld   = '0;
    for (int p = 0; p < int'(NUM_RD_PORTS); p++) begin
      win_data[p]  = '0;
      addr_zero[p] = (i_rs_addr[p*AW +: AW] == '0);
      for (int s = int'(NUM_FWD_STAGES) - 1; s >= 0; s--) begin
        if (!addr_zero[p] && i_stg_wr_rd[s] && i_stg_ce[s] &&
            (i_rs_addr[p*AW +: AW] == i_stg_rd_addr[s*AW +: AW])) begin
          win_any[p]  = 1'b1;
          win_vld[p]  = i_stg_rd_valid[s];
          win_data[p] = i_stg_rd[s*XLEN +: XLEN];
        end
      end
    end
  end

  // Operand select: x0, then forwarded stage, then captured value, then basereg
  always_comb begin
    o_rs = '0;
    for (int p = 0; p < int'(NUM_RD_PORTS); p++) begin
      if (addr_zero[p]) begin
        o_rs[p*XLEN +: XLEN] = '0;
      end else if (win_any[p]) begin
        o_rs[p*XLEN +: XLEN] = win_data[p];
      end else if (cap_vld[p]) begin
        o_rs[p*XLEN +: XLEN] = cap_data[p];
      end else begin
        o_rs[p*XLEN +: XLEN] = i_rs_orig[p*XLEN +: XLEN];
      end
    end
  end

  // A winner whose data is not ready yet stalls. An older valid hit never
  // masks it, because only the winning stage is considered.
  always_comb begin
    stall_raw         = |(win_any & ~win_vld);
    o_alu_force_stall = stall_raw & ~i_rst;
  end

  // Capture buffer: consuming or flushing the operand takes priority over
  // capturing, and the newest valid producer overwrites an older capture.
  always_ff @(posedge i_clk) begin
    for (int p = 0; p < int'(NUM_RD_PORTS); p++) begin
      if (i_rst) begin
        cap_vld[p]  <= 1'b0;
        cap_data[p] <= '0;
      end else if (i_flush || i_alu_ce) begin
        cap_vld[p]  <= 1'b0;
      end else if (win_any[p] && win_vld[p]) begin
        cap_vld[p]  <= 1'b1;
        cap_data[p] <= win_data[p];
      end
    end
  end

  // Consecutive-stall watchdog. The pulse is registered on the edge where
  // stall_run reaches STALL_TIMEOUT; saturation prevents a re-pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_run       <= '0;
      o_stall_timeout <= 1'b0;
    end else begin
      o_stall_timeout <= o_alu_force_stall && (stall_run == RUN_LAST);
      if (!o_alu_force_stall) begin
        stall_run <= '0;
      end else if (stall_run != RUN_MAX) begin
        stall_run <= stall_run + RUN_W'(1);
      end
    end
  end

  // Saturating stall performance counter, unaffected by flush
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_total <= '0;
    end else if (o_alu_force_stall && (o_stall_total != {CNT_W{1'b1}})) begin
      o_stall_total <= o_stall_total + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32i_forwarding_ctrl.sv
// Scoreboarded bench for rv32i_forwarding_ctrl: each cycle drives inputs
// after the rising edge, queues the expected outputs, and pops/compares
// them on the falling edge.
module tb_rv32i_forwarding_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NP    = 2;
  localparam int unsigned NS    = 2;
  localparam int unsigned CNT_W = 32;

  localparam int SEL_RS0 = 0;
  localparam int SEL_RS1 = 1;
  localparam int SEL_STL = 2;
  localparam int SEL_TO  = 3;
  localparam int SEL_TOT = 4;

  logic                 clk = 1'b0;
  logic                 i_rst;
  logic [NP*XLEN-1:0]   i_rs_orig;
  logic [NP*AW-1:0]     i_rs_addr;
  logic                 i_alu_ce;
  logic                 i_flush;
  logic [NS*AW-1:0]     i_stg_rd_addr;
  logic [NS-1:0]        i_stg_wr_rd;
  logic [NS-1:0]        i_stg_rd_valid;
  logic [NS*XLEN-1:0]   i_stg_rd;
  logic [NS-1:0]        i_stg_ce;
  logic [NP*XLEN-1:0]   o_rs;
  logic                 o_alu_force_stall;
  logic                 o_stall_timeout;
  logic [CNT_W-1:0]     o_stall_total;

  rv32i_forwarding_ctrl dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_rs_orig         (i_rs_orig),
    .i_rs_addr         (i_rs_addr),
    .i_alu_ce          (i_alu_ce),
    .i_flush           (i_flush),
    .i_stg_rd_addr     (i_stg_rd_addr),
    .i_stg_wr_rd       (i_stg_wr_rd),
    .i_stg_rd_valid    (i_stg_rd_valid),
    .i_stg_rd          (i_stg_rd),
    .i_stg_ce          (i_stg_ce),
    .o_rs              (o_rs),
    .o_alu_force_stall (o_alu_force_stall),
    .o_stall_timeout   (o_stall_timeout),
    .o_stall_total     (o_stall_total)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_total = '0;
  logic        pend_stall = 1'b0;

  string       tag_q[$];
  int          sel_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [31:0] v);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    if (sel == SEL_STL) pend_stall = v[0];
  endtask

  // Compare every queued expectation against the settled outputs
  task automatic sample();
    string       tag;
    int          sel;
    logic [31:0] exp;
    logic [31:0] obs;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      tag = tag_q.pop_front();
      sel = sel_q.pop_front();
      exp = exp_q.pop_front();
      case (sel)
        SEL_RS0: obs = o_rs[31:0];
        SEL_RS1: obs = o_rs[63:32];
        SEL_STL: obs = {31'b0, o_alu_force_stall};
        SEL_TO:  obs = {31'b0, o_stall_timeout};
        default: obs = o_stall_total;
      endcase
      check(tag, obs, exp);
    end
    if (pend_stall) exp_total++;
    pend_stall = 1'b0;
  endtask

  task automatic idle();
    i_rst          = 1'b0;
    i_alu_ce       = 1'b1;
    i_flush        = 1'b0;
    i_rs_addr      = {5'd2, 5'd1};
    i_rs_orig      = {32'h0000_2222, 32'h0000_1111};
    i_stg_rd_addr  = '0;
    i_stg_wr_rd    = '0;
    i_stg_rd_valid = '0;
    i_stg_rd       = '0;
    i_stg_ce       = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic port(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] orig);
    i_rs_addr[p*AW +: AW]     = a;
    i_rs_orig[p*XLEN +: XLEN] = orig;
  endtask

  task automatic set_stg(input int s, input logic [AW-1:0] a, input logic wr,
                         input logic vld, input logic [XLEN-1:0] d);
    i_stg_rd_addr[s*AW +: AW]   = a;
    i_stg_wr_rd[s]              = wr;
    i_stg_rd_valid[s]           = vld;
    i_stg_rd[s*XLEN +: XLEN]    = d;
    i_stg_ce[s]                 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_limit: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    idle();
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_exp("rst_stall", SEL_STL, 0);
    push_exp("rst_timeout", SEL_TO, 0);
    push_exp("rst_total", SEL_TOT, 0);
    sample();

    step();
    push_exp("idle_rs0", SEL_RS0, 32'h1111);
    push_exp("idle_rs1", SEL_RS1, 32'h2222);
    push_exp("idle_stall", SEL_STL, 0);
    sample();

    // Youngest stage wins
    step();
    port(0, 5, 32'h1111);
    set_stg(0, 5, 1, 1, 32'h11);
    set_stg(1, 5, 1, 1, 32'h22);
    push_exp("b2b_rs0", SEL_RS0, 32'h11);
    push_exp("b2b_stall", SEL_STL, 0);
    sample();

    step();
    port(0, 5, 32'h1111);
    set_stg(0, 6, 1, 1, 32'h11);
    set_stg(1, 5, 1, 1, 32'h22);
    push_exp("older_hit_rs0", SEL_RS0, 32'h22);
    sample();

    step();
    port(0, 5, 32'h1111);
    set_stg(0, 5, 0, 0, 32'h11);
    set_stg(1, 5, 1, 1, 32'h22);
    push_exp("no_wr_rs0", SEL_RS0, 32'h22);
    push_exp("no_wr_stall", SEL_STL, 0);
    sample();

    // Load-use: valid older hit must not mask the invalid younger winner
    step();
    i_alu_ce = 1'b0;
    port(1, 7, 32'h2222);
    set_stg(0, 7, 1, 0, 32'hDEAD);
    set_stg(1, 7, 1, 1, 32'h99);
    push_exp("ldu_stall", SEL_STL, 1);
    push_exp("ldu_rs1", SEL_RS1, 32'hDEAD);
    sample();

    step();
    port(1, 7, 32'h2222);
    set_stg(1, 7, 1, 1, 32'hABCD);
    push_exp("ldu_done_stall", SEL_STL, 0);
    push_exp("ldu_done_rs1", SEL_RS1, 32'hABCD);
    push_exp("ldu_total", SEL_TOT, 1);
    sample();

    // Capture hold, then clear by ALU consume
    step();
    i_alu_ce = 1'b0;
    port(0, 3, 0);
    set_stg(1, 3, 1, 1, 32'h55);
    push_exp("cap_fwd_rs0", SEL_RS0, 32'h55);
    sample();

    step();
    i_alu_ce = 1'b0;
    port(0, 3, 0);
    push_exp("cap_hold_rs0", SEL_RS0, 32'h55);
    push_exp("cap_hold_rs1", SEL_RS1, 32'h2222);
    sample();

    step();
    port(0, 3, 0);
    push_exp("cap_consume_rs0", SEL_RS0, 32'h55);
    sample();

    step();
    i_alu_ce = 1'b0;
    port(0, 3, 0);
    push_exp("cap_clr_ce_rs0", SEL_RS0, 0);
    sample();

    // Newest capture overwrites, then flush clears
    step();
    i_alu_ce = 1'b0;
    port(0, 3, 0);
    set_stg(1, 3, 1, 1, 32'h55);
    sample();

    step();
    i_alu_ce = 1'b0;
    port(0, 3, 0);
    set_stg(0, 3, 1, 1, 32'h66);
    push_exp("recap_fwd_rs0", SEL_RS0, 32'h66);
    sample();

    step();
    i_alu_ce = 1'b0;
    port(0, 3, 0);
    push_exp("cap_newest_rs0", SEL_RS0, 32'h66);
    sample();

    step();
    i_alu_ce = 1'b0;
    i_flush  = 1'b1;
    port(0, 3, 0);
    push_exp("flush_cycle_rs0", SEL_RS0, 32'h66);
    sample();

    step();
    i_alu_ce = 1'b0;
    port(0, 3, 0);
    push_exp("cap_clr_flush_rs0", SEL_RS0, 0);
    push_exp("flush_keeps_total", SEL_TOT, 1);
    sample();

    // Consume and capture in the same cycle: clear wins
    step();
    port(0, 3, 0);
    set_stg(1, 3, 1, 1, 32'h77);
    push_exp("ce_cap_fwd_rs0", SEL_RS0, 32'h77);
    sample();

    step();
    i_alu_ce = 1'b0;
    port(0, 3, 0);
    push_exp("ce_beats_cap_rs0", SEL_RS0, 0);
    sample();

    // x0 never forwards and never stalls
    step();
    port(0, 0, 32'h1234);
    set_stg(0, 0, 1, 0, 32'h77);
    push_exp("x0_rs0", SEL_RS0, 0);
    push_exp("x0_stall", SEL_STL, 0);
    sample();

    // Reset in the middle of a capture and a stall
    step();
    i_alu_ce = 1'b0;
    port(0, 3, 0);
    port(1, 7, 32'h2222);
    set_stg(1, 3, 1, 1, 32'h55);
    set_stg(0, 7, 1, 0, 32'hDEAD);
    push_exp("pre_rst_stall", SEL_STL, 1);
    push_exp("pre_rst_rs0", SEL_RS0, 32'h55);
    push_exp("pre_rst_rs1", SEL_RS1, 32'hDEAD);
    sample();

    step();
    i_rst    = 1'b1;
    i_alu_ce = 1'b0;
    port(0, 3, 0);
    port(1, 7, 32'h2222);
    set_stg(1, 3, 1, 1, 32'h55);
    set_stg(0, 7, 1, 0, 32'hDEAD);
    push_exp("in_rst_stall", SEL_STL, 0);
    push_exp("in_rst_total", SEL_TOT, 2);
    sample();
    exp_total = '0;

    step();
    i_alu_ce = 1'b0;
    port(0, 3, 32'h4444);
    push_exp("post_rst_rs0", SEL_RS0, 32'h4444);
    push_exp("post_rst_total", SEL_TOT, 0);
    push_exp("post_rst_timeout", SEL_TO, 0);
    push_exp("post_rst_stall", SEL_STL, 0);
    sample();

    // Watchdog: 20-cycle stall, pulse only in cycle 16
    for (int k = 1; k <= 20; k++) begin
      step();
      i_alu_ce = 1'b0;
      port(1, 7, 32'h2222);
      set_stg(0, 7, 1, 0, 32'h0);
      push_exp($sformatf("wd1_stall_c%0d", k), SEL_STL, 1);
      push_exp($sformatf("wd1_to_c%0d", k), SEL_TO, (k == 16) ? 32'd1 : 32'd0);
      push_exp($sformatf("wd1_total_c%0d", k), SEL_TOT, exp_total);
      sample();
    end

    step();
    push_exp("wd1_rel_stall", SEL_STL, 0);
    push_exp("wd1_rel_to", SEL_TO, 0);
    push_exp("wd1_rel_total", SEL_TOT, 32'd20);
    sample();

    // Second 15-cycle stall re-arms and pulses once more
    for (int k = 1; k <= 15; k++) begin
      step();
      i_alu_ce = 1'b0;
      port(1, 7, 32'h2222);
      set_stg(0, 7, 1, 0, 32'h0);
      push_exp($sformatf("wd2_stall_c%0d", k), SEL_STL, 1);
      push_exp($sformatf("wd2_to_c%0d", k), SEL_TO, 0);
      sample();
    end

    step();
    push_exp("wd2_pulse", SEL_TO, 1);
    push_exp("wd2_total", SEL_TOT, 32'd35);
    sample();

    step();
    push_exp("wd2_pulse_end", SEL_TO, 0);
    push_exp("final_total", SEL_TOT, exp_total);
    sample();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
